// File: rtl/ip_tone_generator.sv
// rtl/ip_tone_generator.sv - multi-channel square-wave tone generator with index/data I/O port pair
module ip_tone_generator #(
    parameter int         CHANNELS    = 4,
    parameter int         DIV_WIDTH   = 16,
    parameter int         LEVEL_WIDTH = 8,
    parameter int         TICK_DIV    = 64,
    parameter logic [7:0] IO_ADDRESS  = 8'h10
) (
    input  logic                   clk,
    input  logic                   n_reset,
    input  logic [15:0]            bus_address,
    input  logic                   bus_io,
    input  logic                   bus_read,
    input  logic                   bus_write,
    input  logic [7:0]             bus_write_data,
    output logic                   bus_io_cs,
    output logic                   bus_read_ready,
    output logic [7:0]             bus_read_data,
    output logic                   sample_tick,
    output logic [LEVEL_WIDTH+2:0] mix
);
    localparam int MW = LEVEL_WIDTH + 3;
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_RELOAD = PW'(TICK_DIV - 1);

    logic [5:0]             index_q, index_d;
    logic [DIV_WIDTH-1:0]   div_q [CHANNELS];
    logic [DIV_WIDTH-1:0]   div_d [CHANNELS];
    logic [LEVEL_WIDTH-1:0] vol_q [CHANNELS];
    logic [LEVEL_WIDTH-1:0] vol_d [CHANNELS];
    logic [DIV_WIDTH-1:0]   count_q [CHANNELS];
    logic [DIV_WIDTH-1:0]   count_d [CHANNELS];
    logic [CHANNELS-1:0]    en_q, en_d, phase_q, phase_d, active;
    logic                   men_q, men_d;
    logic [PW-1:0]          presc_q, presc_d;
    logic                   tick_q, tick_d;
    logic [MW-1:0]          mix_q, mix_d, mix_sum;
    logic                   rd_ready_q, rd_ready_d;
    logic [7:0]             rd_data_q, rd_data_d, rd_val;
    logic                   index_wr, data_wr, port_rd;
    logic                   unused_addr_hi;

    assign unused_addr_hi = ^bus_address[15:8];
    assign bus_io_cs      = bus_io & (bus_address[7:1] == IO_ADDRESS[7:1]);
    assign index_wr       = bus_io_cs & bus_write & ~bus_address[0];
    assign data_wr        = bus_io_cs & bus_write & bus_address[0];
    assign port_rd        = bus_io_cs & bus_read;

    assign bus_read_ready = rd_ready_q;
    assign bus_read_data  = rd_data_q;
    assign sample_tick    = tick_q;
    assign mix            = mix_q;

    always_comb begin
        rd_val = 8'hFF;
        if (index_q == 6'h3F) begin
            rd_val = {7'b0, men_q};
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (index_q[5:2] == 4'(c)) begin
                    case (index_q[1:0])
                        2'd0:    rd_val = div_q[c][7:0];
                        2'd1:    rd_val = 8'(div_q[c] >> 8);
                        2'd2:    rd_val = 8'(vol_q[c]);
                        default: rd_val = {7'b0, en_q[c]};
                    endcase
                end
            end
        end
        rd_ready_d = port_rd;
        rd_data_d  = rd_data_q;
        if (port_rd) rd_data_d = bus_address[0] ? rd_val : {2'b00, index_q};
    end

    always_comb begin
        index_d = index_q;
        div_d   = div_q;
        vol_d   = vol_q;
        en_d    = en_q;
        men_d   = men_q;
        if (index_wr) index_d = bus_write_data[5:0];
        if (data_wr) begin
            if (index_q == 6'h3F) begin
                men_d = bus_write_data[0];
            end else begin
                for (int c = 0; c < CHANNELS; c++) begin
                    if (index_q[5:2] == 4'(c)) begin
                        case (index_q[1:0])
                            2'd0:    div_d[c] = {div_q[c][DIV_WIDTH-1:8], bus_write_data};
                            2'd1:    div_d[c] = {bus_write_data[DIV_WIDTH-9:0], div_q[c][7:0]};
                            2'd2:    vol_d[c] = bus_write_data[LEVEL_WIDTH-1:0];
                            default: en_d[c]  = bus_write_data[0];
                        endcase
                    end
                end
            end
        end
    end

    // Tone state always sees the pre-write register values, so a write landing on a tick takes effect afterwards.
    always_comb begin
        presc_d = (presc_q == '0) ? PRESC_RELOAD : presc_q - PW'(1);
        tick_d  = (presc_d == '0);
        phase_d = phase_q;
        count_d = count_q;
        mix_sum = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            active[c] = en_q[c] & men_q & (div_q[c] != '0);
            if (!active[c]) begin
                phase_d[c] = 1'b0;
                count_d[c] = '0;
            end else if (tick_q) begin
                if (count_q[c] == '0) begin
                    count_d[c] = div_q[c] - DIV_WIDTH'(1);
                    phase_d[c] = ~phase_q[c];
                end else begin
                    count_d[c] = count_q[c] - DIV_WIDTH'(1);
                end
            end
            if (phase_d[c]) mix_sum = mix_sum + MW'(vol_q[c]);
        end
        mix_d = tick_q ? mix_sum : mix_q;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            index_q    <= '0;
            en_q       <= '0;
            phase_q    <= '0;
            men_q      <= 1'b0;
            presc_q    <= '0;
            tick_q     <= 1'b0;
            mix_q      <= '0;
            rd_ready_q <= 1'b0;
            rd_data_q  <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                div_q[c]   <= '0;
                vol_q[c]   <= '0;
                count_q[c] <= '0;
            end
        end else begin
            index_q    <= index_d;
            en_q       <= en_d;
            phase_q    <= phase_d;
            men_q      <= men_d;
            presc_q    <= presc_d;
            tick_q     <= tick_d;
            mix_q      <= mix_d;
            rd_ready_q <= rd_ready_d;
            rd_data_q  <= rd_data_d;
            div_q      <= div_d;
            vol_q      <= vol_d;
            count_q    <= count_d;
        end
    end
endmodule

// File: tb/tb_ip_tone_generator.sv
// tb/tb_ip_tone_generator.sv - directed and randomized bench for ip_tone_generator
module tb_ip_tone_generator;
    localparam int CH = 4;
    localparam int TD = 64;
    localparam logic [7:0] IOA = 8'h10;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic [15:0] bus_address = '0;
    logic        bus_io = 1'b0, bus_read = 1'b0, bus_write = 1'b0;
    logic [7:0]  bus_write_data = '0;
    logic        bus_io_cs, bus_read_ready, sample_tick;
    logic [7:0]  bus_read_data;
    logic [10:0] mix;

    ip_tone_generator dut (
        .clk(clk), .n_reset(n_reset), .bus_address(bus_address), .bus_io(bus_io),
        .bus_read(bus_read), .bus_write(bus_write), .bus_write_data(bus_write_data),
        .bus_io_cs(bus_io_cs), .bus_read_ready(bus_read_ready), .bus_read_data(bus_read_data),
        .sample_tick(sample_tick), .mix(mix)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0, clk_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: absolute tick numbers for the next toggle instead of a down-counter.
    int m_idx, m_men, m_tickno, m_cyc, m_sum;
    int m_div[CH], m_vol[CH], m_en[CH], m_lvl[CH], m_armed[CH], m_next[CH];
    int e_mix, e_tick, e_ready, e_data;
    bit m_tk, m_cs;

    function automatic int mread(input int idx);
        int ch;
        ch = idx >> 2;
        if (idx == 63) return m_men;
        if (ch >= CH) return 255;
        case (idx & 3)
            0:       return m_div[ch] & 255;
            1:       return (m_div[ch] >> 8) & 255;
            2:       return m_vol[ch];
            default: return m_en[ch];
        endcase
    endfunction

    task automatic reset_model();
        m_idx = 0; m_men = 0; m_tickno = 0; m_cyc = 0;
        e_mix = 0; e_tick = 0; e_ready = 0; e_data = 0;
        for (int c = 0; c < CH; c++) begin
            m_div[c] = 0; m_vol[c] = 0; m_en[c] = 0; m_lvl[c] = 0; m_armed[c] = 0; m_next[c] = 0;
        end
    endtask

    task automatic step_model();
        int d;
        m_tk = (m_cyc > 0) && (m_cyc % TD == 0);
        for (int c = 0; c < CH; c++) begin
            if (!(m_en[c] != 0 && m_men != 0 && m_div[c] != 0)) begin
                m_lvl[c] = 0;
                m_armed[c] = 0;
            end else if (m_tk && (m_armed[c] == 0 || m_next[c] == m_tickno)) begin
                m_lvl[c] = 1 - m_lvl[c];
                m_next[c] = m_tickno + m_div[c];
                m_armed[c] = 1;
            end
        end
        if (m_tk) begin
            m_sum = 0;
            for (int c = 0; c < CH; c++) if (m_lvl[c] != 0) m_sum += m_vol[c];
            e_mix = m_sum;
            m_tickno++;
        end
        m_cs = bus_io && (bus_address[7:1] == IOA[7:1]);
        e_ready = (m_cs && bus_read) ? 1 : 0;
        if (e_ready != 0) e_data = bus_address[0] ? mread(m_idx) : m_idx;
        if (m_cs && bus_write) begin
            d = int'(bus_write_data);
            if (!bus_address[0]) m_idx = d & 63;
            else if (m_idx == 63) m_men = d & 1;
            else if ((m_idx >> 2) < CH) begin
                case (m_idx & 3)
                    0:       m_div[m_idx >> 2] = (m_div[m_idx >> 2] & 32'hFF00) | d;
                    1:       m_div[m_idx >> 2] = (m_div[m_idx >> 2] & 255) | (d << 8);
                    2:       m_vol[m_idx >> 2] = d;
                    default: m_en[m_idx >> 2] = d & 1;
                endcase
            end
        end
        m_cyc++;
        e_tick = (m_cyc % TD == 0) ? 1 : 0;
    endtask

    initial begin
        reset_model();
        forever begin
            @(posedge clk or negedge n_reset);
            if (!n_reset) reset_model();
            else step_model();
        end
    end

    initial forever begin
        @(posedge clk);
        clk_cnt++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        check("mix", int'(mix), e_mix);
        check("sample_tick", int'(sample_tick), e_tick);
        check("read_ready", int'(bus_read_ready), e_ready);
        check("read_data", int'(bus_read_data), e_data);
        check("io_cs", int'(bus_io_cs), int'(bus_io && (bus_address[7:1] == IOA[7:1])));
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic io_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        bus_io = 1'b1; bus_address = a; bus_write_data = d; bus_write = 1'b1;
        @(negedge clk);
        bus_write = 1'b0; bus_io = 1'b0;
    endtask

    task automatic io_read(input logic [15:0] a, output logic [7:0] d);
        @(negedge clk);
        bus_io = 1'b1; bus_address = a; bus_read = 1'b1;
        @(negedge clk);
        bus_read = 1'b0; bus_io = 1'b0;
        check("read_pulse", int'(bus_read_ready), 1);
        d = bus_read_data;
    endtask

    task automatic set_reg(input int idx, input int val);
        io_write(16'h0010, 8'(idx));
        io_write(16'h0011, 8'(val));
    endtask

    task automatic get_reg(input int idx, output int val);
        logic [7:0] d;
        io_write(16'h0010, 8'(idx));
        io_read(16'h0011, d);
        val = int'(d);
    endtask

    int last_tick_at = 0;
    task automatic wait_tick(output int m);
        int k;
        k = 0;
        @(negedge clk);
        while (!sample_tick && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) check("tick_timeout", 0, 1);
        last_tick_at = clk_cnt;
        @(negedge clk);
        m = int'(mix);
    endtask

    task automatic do_reset();
        @(negedge clk);
        n_reset = 1'b0;
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
    endtask

    int v, m, k, prev;
    int t2_exp[6] = '{'h80, 'h80, 0, 0, 'h80, 'h80};
    int t3_exp[7] = '{'h1FE, 'h1FE, 'h1FE, 0, 0, 0, 'h1FE};
    logic [7:0] rd;

    initial begin
        repeat (3) @(negedge clk);
        n_reset = 1'b1;

        get_reg(63, v);
        check("t1_men_reset", v, 0);
        io_read(16'h0010, rd);
        check("t1_index_readback", int'(rd), 'h3F);

        set_reg(0, 2); set_reg(1, 0); set_reg(2, 'h80); set_reg(3, 1); set_reg(63, 1);
        for (int i = 0; i < 6; i++) begin
            prev = last_tick_at;
            wait_tick(m);
            check("t2_mix", m, t2_exp[i]);
            if (i > 0) check("t2_tick_period", last_tick_at - prev, TD);
        end

        do_reset();
        set_reg(0, 3); set_reg(2, 'hFF); set_reg(3, 1);
        set_reg(4, 3); set_reg(6, 'hFF); set_reg(7, 1); set_reg(63, 1);
        for (int i = 0; i < 7; i++) begin
            wait_tick(m);
            check("t3_mix", m, t3_exp[i]);
        end

        do_reset();
        set_reg(0, 5); set_reg(2, 'h80); set_reg(3, 1); set_reg(63, 1);
        wait_tick(m);
        check("t4_first_high", m, 'h80);
        wait_tick(m);
        k = 1;
        set_reg(0, 2);
        do begin wait_tick(m); k++; end while (m != 0 && k < 20);
        check("t4_old_half_period", k, 5);
        k = 0;
        do begin wait_tick(m); k++; end while (m != 'h80 && k < 20);
        check("t4_new_half_period", k, 2);
        k = 0;
        do begin wait_tick(m); k++; end while (m != 0 && k < 20);
        check("t4_new_half_period2", k, 2);

        k = 0;
        do begin wait_tick(m); k++; end while (m != 'h80 && k < 20);
        set_reg(63, 0);
        wait_tick(m);
        check("t5_men_off_mix", m, 0);
        set_reg(63, 1);
        wait_tick(m);
        check("t5_men_on_mix", m, 'h80);

        get_reg('h20, v);
        check("t6_unmapped_read", v, 'hFF);
        k = 0;
        do begin wait_tick(m); k++; end while (m == 0 && k < 20);
        @(posedge clk);
        #3;
        n_reset = 1'b0;
        #1;
        check("t6_async_mix_clear", int'(mix), 0);
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        io_read(16'h0010, rd);
        check("t6_index_reset", int'(rd), 0);
        get_reg(0, v);  check("t6_div_lo_reset", v, 0);
        get_reg(2, v);  check("t6_vol_reset", v, 0);
        get_reg(3, v);  check("t6_en_reset", v, 0);
        get_reg(63, v); check("t6_men_reset", v, 0);

        for (int it = 0; it < 300; it++) begin
            int r;
            logic [15:0] a;
            r = $urandom_range(0, 9);
            if (r <= 1) begin
                if ($urandom_range(0, 9) == 0) v = 63;
                else if ($urandom_range(0, 1) == 0) v = $urandom_range(0, 15);
                else v = $urandom_range(0, 63);
                io_write(16'h0010, 8'(v));
            end else if (r <= 4) begin
                if ((m_idx & 3) == 0) v = $urandom_range(0, 6);
                else if ((m_idx & 3) == 1) v = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : 0;
                else if (m_idx == 63) v = ($urandom_range(0, 3) == 0) ? 0 : 1;
                else v = $urandom_range(0, 255);
                io_write(16'h0011, 8'(v));
            end else if (r == 5) begin
                io_read($urandom_range(0, 1) ? 16'h0011 : 16'h0010, rd);
            end else if (r == 6) begin
                a = 16'($urandom_range(0, 65535));
                if (a[7:1] == IOA[7:1]) a[3] = ~a[3];
                @(negedge clk);
                bus_io = ($urandom_range(0, 1) == 0);
                if (!bus_io && $urandom_range(0, 1) == 0) a = 16'h0011;
                bus_address = a;
                bus_write_data = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 1) == 0) bus_write = 1'b1; else bus_read = 1'b1;
                @(negedge clk);
                bus_write = 1'b0; bus_read = 1'b0; bus_io = 1'b0;
            end else begin
                repeat ($urandom_range(1, 300)) @(negedge clk);
            end
        end

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
